// File: rtl/mul_tdm_scheduler.sv
// mul_tdm_scheduler: shares one constant-time multiplier between requesters A and B
// using fixed alternating slots, so each requester's latency never depends on the other.
module mul_tdm_scheduler #(
  parameter int WIDTH     = 4,
  parameter int SLOT_LEN  = 8,
  parameter bit DUMMY_OPS = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_a,
  input  logic [WIDTH-1:0]   req_multiplier_a,
  input  logic [WIDTH-1:0]   req_multiplicand_a,
  output logic               req_ready_a,
  output logic               resp_valid_a,
  output logic [2*WIDTH-1:0] resp_product_a,
  output logic               resp_err_a,
  input  logic               req_valid_b,
  input  logic [WIDTH-1:0]   req_multiplier_b,
  input  logic [WIDTH-1:0]   req_multiplicand_b,
  output logic               req_ready_b,
  output logic               resp_valid_b,
  output logic [2*WIDTH-1:0] resp_product_b,
  output logic               resp_err_b,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_multiplier,
  output logic [WIDTH-1:0]   mul_multiplicand,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_done
);
  localparam int CW = (SLOT_LEN > 2) ? $clog2(SLOT_LEN) : 2;
  localparam logic [CW-1:0] LAST = CW'(SLOT_LEN - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic run_q, run_d;
  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic owner_q, owner_d;
  logic active_q, active_d, captured_q, captured_d;
  logic [WIDTH-1:0] mr_q, mr_d, md_q, md_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic rv_a_q, rv_a_d, rv_b_q, rv_b_d, err_a_q, err_a_d, err_b_q, err_b_d;
  logic [2*WIDTH-1:0] prod_a_q, prod_a_d, prod_b_q, prod_b_d, fin_prod;
  logic slot0, last, acc_a, acc_b, hit, fin, ok;
  // run_q holds the schedule at slot 0 until the first edge after reset release
  always_comb begin
    slot0 = run_q && slot_cnt_q == '0;
    last = slot_cnt_q == LAST;
    acc_a = slot0 && !owner_q && req_valid_a;
    acc_b = slot0 && owner_q && req_valid_b;
    hit = active_q && !captured_q && mul_done && slot_cnt_q > ONE;
    fin = last && active_q;
    ok = captured_q || hit;
    fin_prod = captured_q ? prod_q : hit ? mul_product : '0;
    run_d = 1'b1;
    slot_cnt_d = (!run_q || last) ? '0 : slot_cnt_q + ONE;
    owner_d = owner_q ^ last;
    active_d = acc_a || acc_b || (active_q && !last);
    captured_d = ok && !last;
    prod_d = hit ? mul_product : prod_q;
    mr_d = acc_a ? req_multiplier_a : acc_b ? req_multiplier_b : (slot0 && DUMMY_OPS) ? '0 : mr_q;
    md_d = acc_a ? req_multiplicand_a : acc_b ? req_multiplicand_b : (slot0 && DUMMY_OPS) ? '0 : md_q;
    rv_a_d = fin && !owner_q;
    rv_b_d = fin && owner_q;
    prod_a_d = rv_a_d ? fin_prod : prod_a_q;
    prod_b_d = rv_b_d ? fin_prod : prod_b_q;
    err_a_d = rv_a_d ? !ok : err_a_q;
    err_b_d = rv_b_d ? !ok : err_b_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
      slot_cnt_q <= '0;
      owner_q <= 1'b0;
      active_q <= 1'b0;
      captured_q <= 1'b0;
      mr_q <= '0;
      md_q <= '0;
      prod_q <= '0;
      rv_a_q <= 1'b0;
      rv_b_q <= 1'b0;
      prod_a_q <= '0;
      prod_b_q <= '0;
      err_a_q <= 1'b0;
      err_b_q <= 1'b0;
    end else begin
      run_q <= run_d;
      slot_cnt_q <= slot_cnt_d;
      owner_q <= owner_d;
      active_q <= active_d;
      captured_q <= captured_d;
      mr_q <= mr_d;
      md_q <= md_d;
      prod_q <= prod_d;
      rv_a_q <= rv_a_d;
      rv_b_q <= rv_b_d;
      prod_a_q <= prod_a_d;
      prod_b_q <= prod_b_d;
      err_a_q <= err_a_d;
      err_b_q <= err_b_d;
    end
  end
  assign req_ready_a = slot0 && !owner_q;
  assign req_ready_b = slot0 && owner_q;
  assign mul_start = run_q && slot_cnt_q == ONE && (active_q || DUMMY_OPS);
  assign mul_multiplier = mr_q;
  assign mul_multiplicand = md_q;
  assign resp_valid_a = rv_a_q;
  assign resp_valid_b = rv_b_q;
  assign resp_product_a = prod_a_q;
  assign resp_product_b = prod_b_q;
  assign resp_err_a = err_a_q;
  assign resp_err_b = err_b_q;
endmodule

// File: tb/tb_mul_tdm_scheduler.sv
// tb_mul_tdm_scheduler: slot-arithmetic reference model plus a behavioural multiplier,
// with a directed transaction table, reset/abort sequences and a random phase.
module tb_mul_tdm_scheduler;
  localparam int W = 4, L = 8;
  logic clk, rst;
  logic req_valid_a, req_valid_b, mul_done;
  logic [W-1:0] req_multiplier_a, req_multiplicand_a, req_multiplier_b, req_multiplicand_b;
  logic [2*W-1:0] mul_product;
  logic req_ready_a, req_ready_b, resp_valid_a, resp_valid_b, resp_err_a, resp_err_b, mul_start;
  logic [2*W-1:0] resp_product_a, resp_product_b;
  logic [W-1:0] mul_multiplier, mul_multiplicand;
  logic d_ready_a, d_ready_b, d_rv_a, d_rv_b, d_err_a, d_err_b, d_start;
  logic [2*W-1:0] d_prod_a, d_prod_b;
  logic [W-1:0] d_mr, d_md;

  mul_tdm_scheduler #(.WIDTH(W), .SLOT_LEN(L), .DUMMY_OPS(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req_valid_a(req_valid_a), .req_multiplier_a(req_multiplier_a), .req_multiplicand_a(req_multiplicand_a),
    .req_ready_a(req_ready_a), .resp_valid_a(resp_valid_a), .resp_product_a(resp_product_a), .resp_err_a(resp_err_a),
    .req_valid_b(req_valid_b), .req_multiplier_b(req_multiplier_b), .req_multiplicand_b(req_multiplicand_b),
    .req_ready_b(req_ready_b), .resp_valid_b(resp_valid_b), .resp_product_b(resp_product_b), .resp_err_b(resp_err_b),
    .mul_start(mul_start), .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_product(mul_product), .mul_done(mul_done));

  mul_tdm_scheduler #(.WIDTH(W), .SLOT_LEN(L), .DUMMY_OPS(1'b1)) dut_dummy (
    .clk(clk), .rst(rst),
    .req_valid_a(1'b0), .req_multiplier_a(req_multiplier_a), .req_multiplicand_a(req_multiplicand_a),
    .req_ready_a(d_ready_a), .resp_valid_a(d_rv_a), .resp_product_a(d_prod_a), .resp_err_a(d_err_a),
    .req_valid_b(1'b0), .req_multiplier_b(req_multiplier_b), .req_multiplicand_b(req_multiplicand_b),
    .req_ready_b(d_ready_b), .resp_valid_b(d_rv_b), .resp_product_b(d_prod_b), .resp_err_b(d_err_b),
    .mul_start(d_start), .mul_multiplier(d_mr), .mul_multiplicand(d_md),
    .mul_product(mul_product), .mul_done(mul_done));

  typedef struct {
    logic va; logic [W-1:0] ma, na;
    logic vb; logic [W-1:0] mb, nb;
    int lat;
    logic [2*W-1:0] pa; bit ea;
    logic [2*W-1:0] pb; bit eb;
  } vec_t;

  int n_chk, n_fail, k, dir_lat, spur_pct, cur_own, cur_lat, cur_mr, cur_md;
  bit rnd_mode, cur_act, cur_got;
  bit drop [2];
  logic [W-1:0] exp_mr, exp_md;
  logic [2*W-1:0] exp_prod [2];
  bit exp_err [2];
  int acc_k [2], rv_k [2];
  logic [2*W-1:0] rv_prod [2];
  bit rv_err [2];
  vec_t tbl [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0h want %0h", nm, k, act, exp);
    end
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      req_valid_a = 1'($urandom); req_valid_b = 1'($urandom);
      req_multiplier_a = 4'($urandom); req_multiplicand_a = 4'($urandom);
      req_multiplier_b = 4'($urandom); req_multiplicand_b = 4'($urandom);
      mul_done = 1'($urandom); mul_product = 8'($urandom);
      #1;
      chk("reset_outs", {req_ready_a, req_ready_b, resp_valid_a, resp_valid_b, resp_product_a, resp_product_b,
                         resp_err_a, resp_err_b, mul_start, mul_multiplier, mul_multiplicand}, 64'd0);
      chk("reset_outs_dummy", {d_ready_a, d_ready_b, d_rv_a, d_rv_b, d_prod_a, d_prod_b,
                               d_err_a, d_err_b, d_start, d_mr, d_md}, 64'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    req_valid_a = 1'b0; req_valid_b = 1'b0; mul_done = 1'b0;
    drop = '{0, 0}; k = 0; cur_act = 0; exp_mr = '0; exp_md = '0;
    exp_prod = '{8'd0, 8'd0}; exp_err = '{0, 0};
  endtask

  // One clock of reference model: slot position and owner follow from the cycle count alone
  task automatic cycle();
    int pos, own;
    bit erv [2];
    @(negedge clk);
    if (drop[0]) req_valid_a = 1'b0;
    if (drop[1]) req_valid_b = 1'b0;
    drop = '{0, 0};
    pos = k % L;
    own = (k / L) % 2;
    erv = '{0, 0};
    if (pos == 0 && cur_act) begin
      erv[cur_own] = 1;
      exp_prod[cur_own] = cur_got ? 8'(cur_mr * cur_md) : 8'd0;
      exp_err[cur_own] = !cur_got;
      cur_act = 0;
    end
    chk("req_ready_a", req_ready_a, pos == 0 && own == 0);
    chk("req_ready_b", req_ready_b, pos == 0 && own == 1);
    chk("resp_valid_a", resp_valid_a, erv[0]);
    chk("resp_valid_b", resp_valid_b, erv[1]);
    chk("resp_product_a", resp_product_a, exp_prod[0]);
    chk("resp_product_b", resp_product_b, exp_prod[1]);
    chk("resp_err_a", resp_err_a, exp_err[0]);
    chk("resp_err_b", resp_err_b, exp_err[1]);
    chk("mul_start", mul_start, cur_act && pos == 1);
    chk("mul_operands", {mul_multiplier, mul_multiplicand}, {exp_mr, exp_md});
    chk("dummy_start", d_start, pos == 1);
    chk("dummy_quiet", {d_mr, d_md, d_rv_a, d_rv_b}, 64'd0);
    if (resp_valid_a) begin rv_k[0] = k; rv_prod[0] = resp_product_a; rv_err[0] = resp_err_a; end
    if (resp_valid_b) begin rv_k[1] = k; rv_prod[1] = resp_product_b; rv_err[1] = resp_err_b; end
    if (rnd_mode) begin
      if (!req_valid_a) begin
        req_multiplier_a = 4'($urandom); req_multiplicand_a = 4'($urandom);
        req_valid_a = ($urandom_range(3) == 0);
      end
      if (!req_valid_b) begin
        req_multiplier_b = 4'($urandom); req_multiplicand_b = 4'($urandom);
        req_valid_b = ($urandom_range(3) == 0);
      end
    end
    if (pos == 0 && (own == 0 ? req_valid_a : req_valid_b)) begin
      cur_act = 1; cur_own = own; cur_got = 0;
      cur_mr = int'(own == 0 ? req_multiplier_a : req_multiplier_b);
      cur_md = int'(own == 0 ? req_multiplicand_a : req_multiplicand_b);
      exp_mr = 4'(cur_mr); exp_md = 4'(cur_md);
      cur_lat = rnd_mode ? (($urandom_range(5) == 0) ? 99 : int'($urandom_range(1, L - 2))) : dir_lat;
      acc_k[own] = k;
      drop[own] = 1;
    end
    mul_done = 1'b0;
    mul_product = 8'($urandom);
    if (cur_act && pos >= 2 && !cur_got) begin
      if (pos == 1 + cur_lat) begin
        mul_done = 1'b1;
        mul_product = 8'(int'(mul_multiplier) * int'(mul_multiplicand));
        cur_got = 1;
      end
    end else if (int'($urandom_range(99)) < spur_pct) mul_done = 1'b1;
    k++;
  endtask

  task automatic run_vec(vec_t v);
    int start;
    while (k % (2 * L) != 0) cycle();
    acc_k = '{-1, -1}; rv_k = '{-1, -1};
    dir_lat = v.lat;
    start = k;
    req_valid_a = v.va; req_multiplier_a = v.ma; req_multiplicand_a = v.na;
    req_valid_b = v.vb; req_multiplier_b = v.mb; req_multiplicand_b = v.nb;
    repeat (3 * L) cycle();
    if (v.va) begin
      chk("vec_accept_a", acc_k[0], start);
      chk("vec_latency_a", rv_k[0], start + L);
      chk("vec_product_a", rv_prod[0], v.pa);
      chk("vec_err_a", rv_err[0], v.ea);
    end
    if (v.vb) begin
      chk("vec_accept_b", acc_k[1], start + L);
      chk("vec_latency_b", rv_k[1], start + 2 * L);
      chk("vec_product_b", rv_prod[1], v.pb);
      chk("vec_err_b", rv_err[1], v.eb);
    end
    if (v.va && v.vb) chk("resp_a_with_ready_b", rv_k[0], acc_k[1]);
  endtask

  initial begin
    tbl[0] = '{1, 3, 5, 0, 0, 0, 3, 15, 0, 0, 0};
    tbl[1] = '{1, 15, 15, 0, 0, 0, 6, 225, 0, 0, 0};
    tbl[2] = '{1, 2, 7, 1, 9, 4, 2, 14, 0, 36, 0};
    tbl[3] = '{1, 6, 6, 0, 0, 0, 99, 0, 1, 0, 0};
    tbl[4] = '{0, 0, 0, 1, 0, 15, 1, 0, 0, 0, 0};
    tbl[5] = '{1, 12, 13, 1, 11, 13, 99, 0, 1, 0, 1};
    n_chk = 0; n_fail = 0; k = 0; rnd_mode = 0; spur_pct = 0; dir_lat = 3;
    rst = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0; mul_done = 1'b0; mul_product = '0;
    req_multiplier_a = '0; req_multiplicand_a = '0; req_multiplier_b = '0; req_multiplicand_b = '0;
    do_reset(3);
    foreach (tbl[i]) run_vec(tbl[i]);
    // done pulses in every empty slot cycle must never surface as a response
    rv_k = '{-1, -1};
    spur_pct = 100;
    repeat (4 * L) cycle();
    chk("spurious_no_resp_a", rv_k[0], -1);
    chk("spurious_no_resp_b", rv_k[1], -1);
    spur_pct = 0;
    // abort an in-flight A operation with a reset pulse four cycles after accept
    while (k % (2 * L) != 0) cycle();
    rv_k = '{-1, -1}; dir_lat = 3;
    req_valid_a = 1'b1; req_multiplier_a = 4'd5; req_multiplicand_a = 4'd6;
    repeat (4) cycle();
    do_reset(2);
    repeat (3 * L) cycle();
    chk("abort_no_resp_a", rv_k[0], -1);
    run_vec('{1, 3, 3, 0, 0, 0, 4, 9, 0, 0, 0});
    rnd_mode = 1; spur_pct = 20;
    repeat (1500) cycle();
    rnd_mode = 0;
    repeat (4 * L) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
